// File: rtl/fa3_pkg.sv
// Shared constants for the fa3 registered ripple-carry adder.
package fa3_pkg;

    localparam int unsigned FA3_WIDTH = 3;

endpackage

// File: rtl/fa3_full_adder.sv
// 1-bit full-adder cell; the unit of the fa3 carry ripple chain.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic sum,
    output logic carry
);

    logic p;

    assign p     = x ^ y;
    assign sum   = p ^ c;
    assign carry = (x & y) | (c & p);

endmodule

// File: rtl/fa3.sv
// Registered WIDTH-bit ripple-carry adder: {cout, s} = a + b + cin, one clock after in_valid.
module fa3
    import fa3_pkg::*;
#(
    parameter int unsigned WIDTH = FA3_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] s_d,    s_q;
    logic             cout_d, cout_q;
    logic             vld_d,  vld_q;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .x     (a[i]),
            .y     (b[i]),
            .c     (carry[i]),
            .sum   (sum[i]),
            .carry (carry[i+1])
        );
    end

    // Sum/carry hold when no valid input; out_valid is a one-cycle pulse.
    always_comb begin
        s_d    = s_q;
        cout_d = cout_q;
        vld_d  = in_valid;
        if (in_valid) begin
            s_d    = sum;
            cout_d = carry[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            vld_q  <= vld_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_fa3.sv
// Self-checking bench for fa3: arithmetic reference model plus directed literal checks.
module tb_fa3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] a, b;
    logic       cin;
    logic [2:0] s;
    logic       cout;
    logic       out_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the outputs must show after the last edge.
    logic [2:0] m_s;
    logic       m_cout;
    logic       m_vld;

    fa3 #(.WIDTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .cout      (cout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        int total;
        if (!rst_n) begin
            m_s    = 3'd0;
            m_cout = 1'b0;
            m_vld  = 1'b0;
        end else begin
            m_vld = in_valid;
            if (in_valid) begin
                total  = int'(a) + int'(b) + int'(cin);
                m_s    = 3'(total % 8);
                m_cout = (total >= 8);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_s",     int'(s),         int'(m_s));
        check("model_cout",  int'(cout),      int'(m_cout));
        check("model_valid", int'(out_valid), int'(m_vld));
    end

    task automatic drive(input logic v, input logic [2:0] ta, input logic [2:0] tb,
                         input logic tc);
        @(posedge clk);
        #2;
        in_valid = v;
        a        = ta;
        b        = tb;
        cin      = tc;
    endtask

    task automatic check_out(input string name, input int es, input int ec, input int ev);
        check({name, "_s"},     int'(s),         es);
        check({name, "_cout"},  int'(cout),      ec);
        check({name, "_valid"}, int'(out_valid), ev);
    endtask

    initial begin
        logic [6:0] combo;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 3'd5;
        b        = 3'd6;
        cin      = 1'b0;
        #1;
        check_out("reset_imm", 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_held", 0, 0, 0);
        #5;
        rst_n    = 1'b1;
        in_valid = 1'b0;

        drive(1'b1, 3'd3, 3'd4, 1'b0);
        drive(1'b0, 3'd0, 3'd0, 1'b0);
        check_out("basic", 7, 0, 1);

        drive(1'b1, 3'd5, 3'd3, 1'b0);
        drive(1'b1, 3'd7, 3'd7, 1'b1);
        check_out("overflow", 0, 1, 1);
        drive(1'b0, 3'd1, 3'd1, 1'b0);
        check_out("maximum", 7, 1, 1);

        drive(1'b1, 3'd2, 3'd1, 1'b1);
        drive(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
        check_out("hold0", 4, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            check_out("hold", 4, 0, 0);
        end

        for (int i = 0; i < 128; i++) begin
            combo = 7'(i);
            drive(1'b1, combo[2:0], combo[5:3], combo[6]);
        end
        drive(1'b0, 3'd0, 3'd0, 1'b0);

        for (int i = 0; i < 200; i++)
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

        drive(1'b1, 3'd7, 3'd6, 1'b0);
        drive(1'b1, 3'd3, 3'd3, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_out("midrst", 0, 0, 0);
        drive(1'b1, 3'd6, 3'd5, 1'b1);
        rst_n = 1'b1;
        #1;
        check_out("midrst_held", 0, 0, 0);
        drive(1'b0, 3'd0, 3'd0, 1'b0);
        check_out("post_rst", 4, 1, 1);
        drive(1'b0, 3'd0, 3'd0, 1'b0);
        check_out("post_rst_idle", 4, 1, 0);

        for (int i = 0; i < 50; i++)
            drive(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
        drive(1'b0, 3'd0, 3'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
